// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if
//   Command channel of the interval-timer controller: a valid/ready handshake
//   carrying an opcode plus the period and prescale used by START commands.
//   The field names match the controller's port names, so the _i/_o suffixes
//   are always seen from the controller's side.
//   Ports (signals):
//     cmd_valid_i     command present
//     cmd_ready_o     controller can accept a command this cycle
//     cmd_op_i        00 START_ONESHOT, 01 START_PERIODIC, 10 STOP, 11 PAUSE_TOGGLE
//     cmd_period_i    terminal count (START only), must be nonzero
//     cmd_prescale_i  prescaler reload (START only)
//   Modports: master = command issuer (CPU/CSR side), slave = timer_ctrl.
interface timer_ctrl_if #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [1:0]            cmd_op_i;
  logic [WIDTH-1:0]      cmd_period_i;
  logic [PRESCALE_W-1:0] cmd_prescale_i;

  modport master (
    output cmd_valid_i,
    output cmd_op_i,
    output cmd_period_i,
    output cmd_prescale_i,
    input  cmd_ready_o
  );

  modport slave (
    input  cmd_valid_i,
    input  cmd_op_i,
    input  cmd_period_i,
    input  cmd_prescale_i,
    output cmd_ready_o
  );
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl
//   Programmable interval-timer controller. An up-counter advances once per
//   prescaler tick (every prescale+1 clocks) while running; reaching the stored
//   period raises a one-cycle expire strobe and either wraps (periodic) or
//   stops (one-shot). Commands arrive over a valid/ready channel.
//   Ports:
//     clk_i       clock, rising edge
//     rst_i       asynchronous reset, active-high
//     cmd         command channel (timer_ctrl_if.slave)
//     cnt_o       current count
//     state_o     00 IDLE, 01 RUN, 10 PAUSED
//     busy_o      state is not IDLE
//     expire_o    one-cycle pulse after the terminal-count tick
//     err_o       one-cycle pulse after a rejected command
//   All outputs are registered.
module timer_ctrl #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  timer_ctrl_if.slave      cmd,
  output logic [WIDTH-1:0] cnt_o,
  output logic [1:0]       state_o,
  output logic             busy_o,
  output logic             expire_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_t;

  localparam logic [1:0] OP_START_ONESHOT  = 2'b00;
  localparam logic [1:0] OP_START_PERIODIC = 2'b01;
  localparam logic [1:0] OP_STOP           = 2'b10;
  localparam logic [1:0] OP_PAUSE_TOGGLE   = 2'b11;

  state_t                state_reg, state_next;
  logic [WIDTH-1:0]      cnt_reg, cnt_next;
  logic [PRESCALE_W-1:0] presc_reg, presc_next;
  logic [WIDTH-1:0]      period_reg, period_next;
  logic [PRESCALE_W-1:0] prescale_reg, prescale_next;
  logic                  periodic_reg, periodic_next;
  logic                  ready_reg, ready_next;
  logic                  expire_reg, expire_next;
  logic                  err_reg, err_next;
  logic                  busy_reg, busy_next;

  logic accept;
  logic tick;
  logic terminal;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      presc_reg    <= '0;
      period_reg   <= '0;
      prescale_reg <= '0;
      periodic_reg <= 1'b0;
      ready_reg    <= 1'b0;
      expire_reg   <= 1'b0;
      err_reg      <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      presc_reg    <= presc_next;
      period_reg   <= period_next;
      prescale_reg <= prescale_next;
      periodic_reg <= periodic_next;
      ready_reg    <= ready_next;
      expire_reg   <= expire_next;
      err_reg      <= err_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    presc_next    = presc_reg;
    period_next   = period_reg;
    prescale_next = prescale_reg;
    periodic_next = periodic_reg;
    expire_next   = 1'b0;
    err_next      = 1'b0;

    accept   = cmd.cmd_valid_i && ready_reg;
    tick     = (state_reg == ST_RUN) && (presc_reg == prescale_reg);
    terminal = tick && (cnt_reg == period_reg);

    // Free-running behaviour of the counter for this edge.
    if (state_reg == ST_RUN) begin
      if (tick) begin
        presc_next = '0;
        if (terminal) begin
          expire_next = 1'b1;
          if (periodic_reg) begin
            cnt_next = '0;
          end else begin
            // One-shot: the count stays parked at the period value.
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + WIDTH'(1);
        end
      end else begin
        presc_next = presc_reg + PRESCALE_W'(1);
      end
    end

    // An accepted command overrides the free-running update above; the
    // expire strobe computed above is deliberately left untouched.
    if (accept) begin
      unique case (cmd.cmd_op_i)
        OP_START_ONESHOT, OP_START_PERIODIC: begin
          if (cmd.cmd_period_i == '0) begin
            // Rejected: only the free-running update above applies.
            err_next = 1'b1;
          end else begin
            period_next   = cmd.cmd_period_i;
            prescale_next = cmd.cmd_prescale_i;
            periodic_next = (cmd.cmd_op_i == OP_START_PERIODIC);
            cnt_next      = '0;
            presc_next    = '0;
            state_next    = ST_RUN;
          end
        end
        OP_STOP: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          presc_next = '0;
        end
        OP_PAUSE_TOGGLE: begin
          // Pausing only changes the state: the edge that accepts the pause
          // was still a RUN edge, so its prescaler/count step is kept, and
          // the resume edge (a PAUSED edge) does not step. That makes the
          // delay equal the number of cycles spent in PAUSED.
          unique case (state_reg)
            ST_RUN:    state_next = ST_PAUSED;
            ST_PAUSED: state_next = ST_RUN;
            default:   err_next   = 1'b1;
          endcase
        end
        default: ;
      endcase
    end

    // Apply latency: one dead cycle after each accepted command.
    ready_next = !accept;
    busy_next  = (state_next != ST_IDLE);
  end

  assign cmd.cmd_ready_o = ready_reg;
  assign cnt_o           = cnt_reg;
  assign state_o         = state_reg;
  assign busy_o          = busy_reg;
  assign expire_o        = expire_reg;
  assign err_o           = err_reg;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl
//   Randomized, scoreboarded bench for timer_ctrl. The reference model counts
//   running edges k since the last start: cnt = k/(S+1) while active, and the
//   terminal event happens when k reaches (P+1)*(S+1).
module tb_timer_ctrl;
  localparam int WIDTH = 16;
  localparam int PW    = 8;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [WIDTH-1:0] cnt_o;
  logic [1:0]       state_o;
  logic             busy_o;
  logic             expire_o;
  logic             err_o;

  always #5 clk_i = ~clk_i;

  timer_ctrl_if #(.WIDTH(WIDTH), .PRESCALE_W(PW)) cmd_if ();

  timer_ctrl #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .cmd      (cmd_if),
    .cnt_o    (cnt_o),
    .state_o  (state_o),
    .busy_o   (busy_o),
    .expire_o (expire_o),
    .err_o    (err_o)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int edge_cnt     = 0;

  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int               tag;
    logic             ready;
    logic [1:0]       state;
    logic             busy;
    logic             expire;
    logic             err;
    logic [WIDTH-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: 0 idle, 1 run, 2 paused.
  int m_state, m_k, m_p, m_s, m_cnt;
  bit m_periodic, m_ready;

  function automatic int m_len();
    return (m_p + 1) * (m_s + 1);
  endfunction

  function automatic int m_cur_cnt();
    return (m_state == 0) ? m_cnt : m_k / (m_s + 1);
  endfunction

  function automatic bit pause_unsafe();
    return (m_state == 1) && !m_periodic && (m_k + 1 == m_len());
  endfunction

  task automatic model_reset();
    m_state = 0; m_k = 0; m_p = 0; m_s = 0; m_cnt = 0;
    m_periodic = 1'b0; m_ready = 1'b0;
  endtask

  task automatic push_exp(input bit e, input bit r);
    exp_t x;
    x.tag    = edge_cnt + 1;
    x.ready  = m_ready;
    x.state  = 2'(m_state);
    x.busy   = (m_state != 0);
    x.expire = e;
    x.err    = r;
    x.cnt    = WIDTH'(m_cur_cnt());
    sb_q.push_back(x);
  endtask

  task automatic check_now(input string name, input int act, input int req);
    tests_run++;
    if (act != req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // One clock of stimulus; the expectation for the following edge is queued.
  task automatic step(input bit v, input logic [1:0] op, input int per, input int pre);
    bit acc, e, r;
    int st0;
    @(posedge clk_i); #1;
    cmd_if.cmd_valid_i    = v;
    cmd_if.cmd_op_i       = op;
    cmd_if.cmd_period_i   = WIDTH'(per);
    cmd_if.cmd_prescale_i = PW'(pre);
    acc = v && m_ready;
    e = 1'b0; r = 1'b0;
    st0 = m_state;
    if (m_state == 1) begin
      m_k++;
      if (m_k == m_len()) begin
        e = 1'b1;
        if (m_periodic) m_k = 0;
        else begin m_state = 0; m_cnt = m_p; end
      end
    end
    if (acc) begin
      case (op)
        2'b00, 2'b01: begin
          if (per == 0) r = 1'b1;
          else begin
            m_p = per; m_s = pre; m_periodic = op[0]; m_k = 0; m_state = 1;
          end
        end
        2'b10: begin m_state = 0; m_cnt = 0; m_k = 0; end
        default: begin
          if (st0 == 0) r = 1'b1;
          else if (st0 == 1) m_state = 2;
          else m_state = 1;
        end
      endcase
    end
    m_ready = !acc;
    push_exp(e, r);
    if (v) $display("[TB] edge %0d cmd op=%0d per=%0d pre=%0d accepted=%0d", edge_cnt + 1, op, per, pre, acc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 2'($urandom), $urandom_range(0, 65535), $urandom_range(0, 255));
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset();
    @(posedge clk_i); #1;
    cmd_if.cmd_valid_i = 1'b0;
    #4 rst_i = 1'b1;
    #1;
    check_now("async_rst cnt",    int'(cnt_o), 0);
    check_now("async_rst state",  int'(state_o), 0);
    check_now("async_rst ready",  int'(cmd_if.cmd_ready_o), 0);
    check_now("async_rst flags",  int'({busy_o, expire_o, err_o}), 0);
    model_reset();
    push_exp(1'b0, 1'b0);
    @(posedge clk_i); #1;
    push_exp(1'b0, 1'b0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    m_ready = 1'b1;
    push_exp(1'b0, 1'b0);
    $display("[TB] edge %0d reset released", edge_cnt);
  endtask

  task automatic wait_for(input string name, input int which, input int val);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      case (which)
        0: ok = (m_state == 1) && (m_cur_cnt() == val) && (m_k % (m_s + 1) == 0);
        default: ok = (m_state == 1) && (m_k + 1 == m_len()) && m_ready;
      endcase
      if (!ok) idle(1);
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL %s: condition not reached, got 0, expected 1", name);
    end
  endtask

  // Monitor: compares DUT outputs with the queued expectation for each edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk_i); #3;
      while (sb_q.size() > 0 && sb_q[0].tag <= edge_cnt) begin
        x = sb_q.pop_front();
        tests_run++;
        if (x.tag != edge_cnt) begin
          tests_failed++;
          $display("[TB] FAIL stale_expectation: got edge %0d, expected edge %0d", edge_cnt, x.tag);
        end else if ({cmd_if.cmd_ready_o, state_o, busy_o, expire_o, err_o, cnt_o} !=
                     {x.ready, x.state, x.busy, x.expire, x.err, x.cnt}) begin
          tests_failed++;
          $display("[TB] FAIL edge_%0d outputs: got rdy=%0d st=%0d busy=%0d exp=%0d err=%0d cnt=%0d, expected rdy=%0d st=%0d busy=%0d exp=%0d err=%0d cnt=%0d",
                   edge_cnt, cmd_if.cmd_ready_o, state_o, busy_o, expire_o, err_o, cnt_o,
                   x.ready, x.state, x.busy, x.expire, x.err, x.cnt);
        end
      end
    end
  end

  initial begin
    cmd_if.cmd_valid_i    = 1'b0;
    cmd_if.cmd_op_i       = 2'b00;
    cmd_if.cmd_period_i   = '0;
    cmd_if.cmd_prescale_i = '0;
    model_reset();
    do_reset();

    // Periodic P=3 S=0.
    step(1'b1, 2'b01, 3, 0);
    idle(12);
    // One-shot P=2 S=1.
    step(1'b1, 2'b00, 2, 1);
    idle(10);
    // Rejected commands.
    step(1'b1, 2'b01, 0, 0);
    idle(1);
    step(1'b1, 2'b11, 5, 5);
    idle(2);
    // Pause at cnt=3 for 10 cycles, then resume.
    step(1'b1, 2'b01, 5, 2);
    wait_for("reach_cnt3", 0, 3);
    step(1'b1, 2'b11, 0, 0);
    idle(10);
    step(1'b1, 2'b11, 0, 0);
    idle(25);
    // STOP on the terminal tick.
    step(1'b1, 2'b01, 1, 0);
    idle(1);
    wait_for("reach_terminal", 1, 0);
    step(1'b1, 2'b10, 0, 0);
    idle(3);
    // Asynchronous reset mid-run at cnt=7.
    step(1'b1, 2'b01, 10, 0);
    wait_for("reach_cnt7", 0, 7);
    do_reset();
    idle(2);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        bit v;
        logic [1:0] op;
        int per;
        v   = ($urandom_range(0, 2) == 0);
        op  = 2'($urandom);
        per = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
        if (op == 2'b11 && pause_unsafe()) v = 1'b0;
        step(v, op, per, $urandom_range(0, 3));
      end
    end

    idle(2);
    @(posedge clk_i); #5;
    check_now("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
